// File: rtl/stopwatch_if.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_if
// Brief   : Control inputs and BCD display outputs of the MM:SS stopwatch.
// Revision: 1.0
// ============================================================================
interface stopwatch_if;
   logic       i_TICK_CLK;
   logic       i_START;
   logic       i_CLEAR;
   logic [3:0] o_SEC_ONES;
   logic [3:0] o_SEC_TENS;
   logic [3:0] o_MIN_ONES;
   logic [3:0] o_MIN_TENS;
   logic       o_RUNNING;
   logic       o_WRAP;
`ifdef STOPWATCH_LAP_EN
   logic       i_LAP;
   logic       o_HOLD;
`endif

   modport master (
`ifdef STOPWATCH_LAP_EN
      output i_LAP,
      input  o_HOLD,
`endif
      output i_TICK_CLK, i_START, i_CLEAR,
      input  o_SEC_ONES, o_SEC_TENS, o_MIN_ONES, o_MIN_TENS, o_RUNNING, o_WRAP
   );

   modport slave (
`ifdef STOPWATCH_LAP_EN
      input  i_LAP,
      output o_HOLD,
`endif
      input  i_TICK_CLK, i_START, i_CLEAR,
      output o_SEC_ONES, o_SEC_TENS, o_MIN_ONES, o_MIN_TENS, o_RUNNING, o_WRAP
   );
endinterface
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_core
// Brief   : Four-digit BCD MM:SS stopwatch counting i_TICK_CLK rising edges;
//           optional lap hold enabled by macro STOPWATCH_LAP_EN.
// Revision: 1.0
// ============================================================================
module stopwatch_core #(
   parameter int unsigned MIN_TENS_MAX = 5
) (
   input  wire logic  i_CLK,
   input  wire logic  i_RST,
   stopwatch_if.slave sw
);
   localparam logic [3:0] c_MIN_TENS_MAX = 4'(MIN_TENS_MAX);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t     r_state;
   logic       r_prev_tick, r_prev_start;
   logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
   logic       r_running, r_wrap;

   logic       w_tick, w_start_edge, w_clear;
   logic [3:0] w_sec_ones, w_sec_tens, w_min_ones, w_min_tens;
   logic       w_wrap;

   // Cascaded BCD increment; a paused clear overrides everything.
   always_comb begin
      w_tick       = sw.i_TICK_CLK & ~r_prev_tick;
      w_start_edge = sw.i_START & ~r_prev_start;
      w_clear      = (r_state == ST_PAUSE) && sw.i_CLEAR;
      w_sec_ones   = r_sec_ones;
      w_sec_tens   = r_sec_tens;
      w_min_ones   = r_min_ones;
      w_min_tens   = r_min_tens;
      w_wrap       = 1'b0;
      if (w_clear) begin
         w_sec_ones = 4'd0;
         w_sec_tens = 4'd0;
         w_min_ones = 4'd0;
         w_min_tens = 4'd0;
      end else if ((r_state == ST_RUN) && w_tick) begin
         if (r_sec_ones != 4'd9) begin
            w_sec_ones = r_sec_ones + 4'd1;
         end else begin
            w_sec_ones = 4'd0;
            if (r_sec_tens != 4'd5) begin
               w_sec_tens = r_sec_tens + 4'd1;
            end else begin
               w_sec_tens = 4'd0;
               if (r_min_ones != 4'd9) begin
                  w_min_ones = r_min_ones + 4'd1;
               end else begin
                  w_min_ones = 4'd0;
                  if (r_min_tens != c_MIN_TENS_MAX) begin
                     w_min_tens = r_min_tens + 4'd1;
                  end else begin
                     w_min_tens = 4'd0;
                     w_wrap     = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Edge history loads even under reset so a level held through reset is not an edge.
   always_ff @(posedge i_CLK) begin
      r_prev_tick  <= sw.i_TICK_CLK;
      r_prev_start <= sw.i_START;
      if (i_RST) begin
         r_state    <= ST_IDLE;
         r_running  <= 1'b0;
         r_wrap     <= 1'b0;
         r_sec_ones <= 4'd0;
         r_sec_tens <= 4'd0;
         r_min_ones <= 4'd0;
         r_min_tens <= 4'd0;
      end else begin
         r_sec_ones <= w_sec_ones;
         r_sec_tens <= w_sec_tens;
         r_min_ones <= w_min_ones;
         r_min_tens <= w_min_tens;
         r_wrap     <= w_wrap;
         case (r_state)
            ST_IDLE: begin
               if (w_start_edge) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_start_edge) begin
                  r_state   <= ST_PAUSE;
                  r_running <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (sw.i_CLEAR) begin
                  r_state   <= ST_IDLE;
                  r_running <= 1'b0;
               end else if (w_start_edge) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   assign sw.o_RUNNING = r_running;
   assign sw.o_WRAP    = r_wrap;

`ifdef STOPWATCH_LAP_EN
   logic        r_prev_lap, r_hold;
   logic [15:0] r_snap, r_disp;
   logic        w_lap_edge, w_hold;
   logic [15:0] w_snap;

   // Snapshot captures the count as it stood when the lap edge arrived.
   always_comb begin
      w_lap_edge = sw.i_LAP & ~r_prev_lap;
      w_hold     = r_hold;
      w_snap     = r_snap;
      if (w_clear) begin
         w_hold = 1'b0;
      end else if (w_lap_edge && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
         w_hold = ~r_hold;
         if (!r_hold) begin
            w_snap = {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
         end
      end
   end

   always_ff @(posedge i_CLK) begin
      r_prev_lap <= sw.i_LAP;
      if (i_RST) begin
         r_hold <= 1'b0;
         r_snap <= 16'd0;
         r_disp <= 16'd0;
      end else begin
         r_hold <= w_hold;
         r_snap <= w_snap;
         r_disp <= w_hold ? w_snap : {w_min_tens, w_min_ones, w_sec_tens, w_sec_ones};
      end
   end

   assign sw.o_HOLD     = r_hold;
   assign sw.o_MIN_TENS = r_disp[15:12];
   assign sw.o_MIN_ONES = r_disp[11:8];
   assign sw.o_SEC_TENS = r_disp[7:4];
   assign sw.o_SEC_ONES = r_disp[3:0];
`else
   assign sw.o_MIN_TENS = r_min_tens;
   assign sw.o_MIN_ONES = r_min_ones;
   assign sw.o_SEC_TENS = r_sec_tens;
   assign sw.o_SEC_ONES = r_sec_ones;
`endif
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_stopwatch_core
// Brief   : Scoreboard bench for stopwatch_core; lap vectors need STOPWATCH_LAP_EN.
// Revision: 1.0
// ============================================================================
module tb_stopwatch_core;
    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_fail;

    stopwatch_if sw_if ();

    stopwatch_core #(.MIN_TENS_MAX(5)) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .sw    (sw_if.slave)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] digits;
        logic        run;
        logic        wrap;
        logic        hold;
    } exp_t;

    exp_t q[$];

    logic        act_hold;
    logic [15:0] w_act;

    assign w_act = {sw_if.o_MIN_TENS, sw_if.o_MIN_ONES, sw_if.o_SEC_TENS, sw_if.o_SEC_ONES};

`ifdef STOPWATCH_LAP_EN
    assign act_hold = sw_if.o_HOLD;
`else
    assign act_hold = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every queued expectation due in the current cycle.
    always @(negedge clk) begin
        logic [15:0] act;
        exp_t        e;
        act = {sw_if.o_MIN_TENS, sw_if.o_MIN_ONES, sw_if.o_SEC_TENS, sw_if.o_SEC_ONES};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec = n_vec + 1;
            if (act !== e.digits || sw_if.o_RUNNING !== e.run ||
                sw_if.o_WRAP !== e.wrap || act_hold !== e.hold) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %h run=%b wrap=%b hold=%b, want %h run=%b wrap=%b hold=%b",
                         e.name, act, sw_if.o_RUNNING, sw_if.o_WRAP, act_hold,
                         e.digits, e.run, e.wrap, e.hold);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input string nm, input logic [15:0] d,
                             input logic r, input logic w, input logic h);
        exp_t e;
        e.cyc = c; e.name = nm; e.digits = d; e.run = r; e.wrap = w; e.hold = h;
        q.push_back(e);
    endtask

    // Expect the given state after the next edge with all inputs idle.
    task automatic chk(input string nm, input logic [15:0] d, input logic r, input logic h);
        expect_at(cyc + 1, nm, d, r, 1'b0, h);
        step();
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            sw_if.i_TICK_CLK = 1'b1;
            step();
            sw_if.i_TICK_CLK = 1'b0;
            step();
        end
    endtask

    task automatic press();
        sw_if.i_START = 1'b1;
        step();
        sw_if.i_START = 1'b0;
        step();
    endtask

    task automatic do_reset();
        sw_if.i_TICK_CLK = 1'b0;
        sw_if.i_START    = 1'b0;
        sw_if.i_CLEAR    = 1'b0;
`ifdef STOPWATCH_LAP_EN
        sw_if.i_LAP      = 1'b0;
`endif
        rst = 1'b1;
        step();
        step();
        expect_at(cyc, "reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        cyc    = 0;
        rst    = 1'b1;
        do_reset();

        // Ticks ignored in IDLE
        tick_n(10);
        chk("idle_ticks", 16'h0000, 1'b0, 1'b0);

        // Start and tick latency, then 75 seconds total
        sw_if.i_START = 1'b1;
        expect_at(cyc,     "start_before", 16'h0000, 1'b0, 1'b0, 1'b0);
        expect_at(cyc + 1, "start_after",  16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        sw_if.i_START = 1'b0;
        step();
        sw_if.i_TICK_CLK = 1'b1;
        expect_at(cyc,     "tick_before", 16'h0000, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 1, "tick_after",  16'h0001, 1'b1, 1'b0, 1'b0);
        step();
        sw_if.i_TICK_CLK = 1'b0;
        step();
        tick_n(74);
        chk("run_75", 16'h0115, 1'b1, 1'b0);
        n_vec = n_vec + 1;
        if (w_act !== 16'h0115 || sw_if.o_RUNNING !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_run_75: got %h run=%b, want 0115 run=1", w_act, sw_if.o_RUNNING);
        end

        // Pause, ticks while paused, clear
        do_reset();
        press();
        tick_n(5);
        press();
        chk("pause_5", 16'h0005, 1'b0, 1'b0);
        tick_n(3);
        chk("paused_ticks", 16'h0005, 1'b0, 1'b0);
        n_vec = n_vec + 1;
        if (w_act !== 16'h0005 || sw_if.o_RUNNING !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_paused: got %h run=%b, want 0005 run=0", w_act, sw_if.o_RUNNING);
        end
        sw_if.i_CLEAR = 1'b1;
        expect_at(cyc + 1, "clear", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        sw_if.i_CLEAR = 1'b0;
        step();
        press();
        tick_n(2);
        chk("run_2", 16'h0002, 1'b1, 1'b0);
        sw_if.i_CLEAR = 1'b1;
        tick_n(3);
        sw_if.i_CLEAR = 1'b0;
        chk("clear_in_run", 16'h0005, 1'b1, 1'b0);

        // Wrap at 59:59
        do_reset();
        press();
        tick_n(3599);
        chk("pre_wrap", 16'h5959, 1'b1, 1'b0);
        n_vec = n_vec + 1;
        if (w_act !== 16'h5959 || sw_if.o_WRAP !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_pre_wrap: got %h wrap=%b, want 5959 wrap=0", w_act, sw_if.o_WRAP);
        end
        sw_if.i_TICK_CLK = 1'b1;
        expect_at(cyc + 1, "wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
        step();
        sw_if.i_TICK_CLK = 1'b0;
        expect_at(cyc + 1, "wrap_end", 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        tick_n(1);
        chk("post_wrap", 16'h0001, 1'b1, 1'b0);

        // Same-cycle events
        sw_if.i_START = 1'b1; sw_if.i_TICK_CLK = 1'b1;
        expect_at(cyc + 1, "run_start_tick", 16'h0002, 1'b0, 1'b0, 1'b0);
        step();
        sw_if.i_START = 1'b0; sw_if.i_TICK_CLK = 1'b0;
        step();
        sw_if.i_START = 1'b1; sw_if.i_TICK_CLK = 1'b1;
        expect_at(cyc + 1, "pause_start_tick", 16'h0002, 1'b1, 1'b0, 1'b0);
        step();
        sw_if.i_START = 1'b0; sw_if.i_TICK_CLK = 1'b0;
        step();
        press();
        chk("paused", 16'h0002, 1'b0, 1'b0);
        sw_if.i_START = 1'b1; sw_if.i_CLEAR = 1'b1;
        expect_at(cyc + 1, "start_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        sw_if.i_START = 1'b0; sw_if.i_CLEAR = 1'b0;
        step();
        tick_n(1);
        chk("idle_tick", 16'h0000, 1'b0, 1'b0);
        sw_if.i_START = 1'b1; sw_if.i_TICK_CLK = 1'b1;
        expect_at(cyc + 1, "idle_start_tick", 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        sw_if.i_START = 1'b0; sw_if.i_TICK_CLK = 1'b0;
        step();
        tick_n(1);
        chk("run_from_idle", 16'h0001, 1'b1, 1'b0);

        // Reset mid-count at 12:34 with tick held through reset
        do_reset();
        press();
        tick_n(754);
        chk("at_1234", 16'h1234, 1'b1, 1'b0);
        sw_if.i_TICK_CLK = 1'b1;
        rst = 1'b1;
        expect_at(cyc + 1, "rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        sw_if.i_TICK_CLK = 1'b0;
        chk("after_rst", 16'h0000, 1'b0, 1'b0);
        n_vec = n_vec + 1;
        if (w_act !== 16'h0000 || sw_if.o_RUNNING !== 1'b0 || sw_if.o_WRAP !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_after_rst: got %h run=%b wrap=%b, want 0000 run=0 wrap=0",
                     w_act, sw_if.o_RUNNING, sw_if.o_WRAP);
        end

`ifdef STOPWATCH_LAP_EN
        // Lap hold freezes display while count advances
        do_reset();
        press();
        tick_n(10);
        sw_if.i_LAP = 1'b1;
        expect_at(cyc + 1, "lap_on", 16'h0010, 1'b1, 1'b0, 1'b1);
        step();
        sw_if.i_LAP = 1'b0;
        step();
        tick_n(5);
        chk("lap_hold", 16'h0010, 1'b1, 1'b1);
        sw_if.i_LAP = 1'b1;
        expect_at(cyc + 1, "lap_off", 16'h0015, 1'b1, 1'b0, 1'b0);
        step();
        sw_if.i_LAP = 1'b0;
        step();
`endif

        step();
        step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: got no sample, want check at cycle %0d", e.name, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stopwatch_core.md
# stopwatch_core

Four-digit BCD stopwatch (MM:SS) that consumes the divided 1 Hz square wave from the clock divider stage and counts its rising edges in the i_CLK domain. A start/pause toggle and a clear input drive a three-state controller. The BCD digit outputs feed the seven-segment display scanner downstream.

## Interface
- MIN_TENS_MAX, 5: highest minutes-tens digit. The count wraps after MIN_TENS_MAX9:59.
- i_CLK  in  1  system clock; the same clock that drives the divider.
- i_RST  in  1  reset, synchronous, active-high; clock i_CLK.
- i_TICK_CLK  in  1  divided square wave, synchronous to i_CLK. Each rising edge is one second.
- i_START  in  1  debounced button level. Each rising edge toggles run/pause.
- i_CLEAR  in  1  level, sampled every cycle. Zeroes the count when not running.
- i_LAP  in  1  debounced button level. Present only with STOPWATCH_LAP_EN.
- o_SEC_ONES  out  4  BCD 0–9.
- o_SEC_TENS  out  4  BCD 0–5.
- o_MIN_ONES  out  4  BCD 0–9.
- o_MIN_TENS  out  4  BCD 0–MIN_TENS_MAX.
- o_RUNNING  out  1  high while state is RUN.
- o_WRAP  out  1  one-cycle pulse when the count rolls over to 00:00.
- o_HOLD  out  1  lap hold active. Present only with STOPWATCH_LAP_EN.

## Operation
- Edge detection:
  - Registers prev_tick, prev_start and prev_lap load their input every cycle, including during reset. Asserting an input during reset therefore produces no edge on release.
  - tick = i_TICK_CLK & ~prev_tick. start_edge and lap_edge are formed the same way.
- States: IDLE (count 00:00), RUN, PAUSE. Encoding is free.
- Transitions:
  - IDLE + start_edge → RUN.
  - RUN + start_edge → PAUSE.
  - PAUSE + start_edge → RUN.
  - PAUSE + i_CLEAR → IDLE, with all digits zeroed.
  - IDLE + i_CLEAR → stays IDLE.
  - RUN + i_CLEAR → ignored.
- Counting happens only when the registered state is RUN and tick=1:
  - sec_ones increments.
  - 9 → 0 carries into sec_tens.
  - sec_tens 5 → 0 carries into min_ones.
  - min_ones 9 → 0 carries into min_tens.
  - min_tens at MIN_TENS_MAX → 0 is a wrap: the count becomes 00:00, o_WRAP=1 for that one cycle, and the state stays RUN.
- Digits never take non-BCD values. No binary counters are converted to BCD.
- Simultaneous events:
  - RUN, start_edge and tick in the same cycle: the tick is counted and the state goes to PAUSE.
  - IDLE or PAUSE, start_edge and tick in the same cycle: the tick is not counted.
  - PAUSE, start_edge and i_CLEAR in the same cycle: clear wins, the state goes to IDLE, and start_edge is discarded.
- Reset at any point, including mid-count or mid-wrap:
  - State goes to IDLE; all digits 0.
  - o_RUNNING=0, o_WRAP=0.
  - With STOPWATCH_LAP_EN: o_HOLD=0 and the snapshot is 0.

## Timing
- All outputs are registered.
- Reset values: every output 0.
- Tick latency: if i_TICK_CLK is first sampled 1 in cycle N (with prev_tick=0), the new digits are visible in cycle N+1.
- start_edge in cycle N → o_RUNNING changes in cycle N+1.
- i_CLEAR asserted in cycle N in PAUSE → digits read 0 in cycle N+1.
- o_WRAP is high for exactly one cycle, the same cycle the 00:00 digits first appear.
- No combinational path from any input to any output.

## Configuration
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - i_LAP and o_HOLD ports exist.
  - In RUN, lap_edge toggles hold. Entering hold snapshots the current digits.
  - While hold=1, the o_* digits show the snapshot and the internal count keeps advancing.
  - hold persists through PAUSE. lap_edge in PAUSE also toggles hold.
  - i_CLEAR that takes effect (PAUSE → IDLE) forces hold=0.
  - hold changes are visible one cycle after lap_edge.
- Undefined:
  - Neither port exists.
  - The digit outputs always show the live count.
  - No snapshot registers are synthesized.

## Test plan
- Reset, then 10 ticks with i_START idle → digits stay 00:00, o_RUNNING=0.
- Start edge, then 75 ticks → 01:15 and o_RUNNING=1. Each digit update lands one cycle after the tick edge is sampled.
- Pause after 5 ticks, apply 3 more ticks, then assert i_CLEAR → digits stay 00:05 while paused, then read 00:00 in IDLE. Repeat with i_CLEAR held during RUN → no effect.
- Preload 59:59 by running 3599 ticks (MIN_TENS_MAX=5), then one more tick → 00:00, a single-cycle o_WRAP, state still RUN.
- Same-cycle events: start_edge with tick in RUN → the tick is counted, then PAUSE. start_edge with i_CLEAR in PAUSE → IDLE. i_RST mid-count at 12:34 → all outputs 0 next cycle.
- With STOPWATCH_LAP_EN: lap at 00:10, then 5 ticks → outputs hold 00:10 with o_HOLD=1. A second lap edge → 00:15 shown and o_HOLD=0.
